// File: rtl/display_scheduler.sv
// Two-requester display scheduler: round-robin grant, signed 8-bit to
// sign + 3 BCD digits by double dabble, result held for DWELL cycles.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req0/val0          requester 0 level request and signed value
//   req1/val1          requester 1 level request and signed value
//   gnt0/gnt1          one-cycle grant pulses
//   busy               conversion in progress
//   valid              digits hold a completed result
//   owner              requester whose result is shown
//   sign               shown value is negative
//   hunds/tens/ones    BCD digits of the magnitude
module display_scheduler #(
  parameter int unsigned DWELL = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] val0,
  input  logic       req1,
  input  logic [7:0] val1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       valid,
  output logic       owner,
  output logic       sign,
  output logic [3:0] hunds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam logic [25:0] DWELL_M1 = 26'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [25:0] dwell_cnt;
  logic [2:0]  bit_cnt;
  logic        last;
  logic        sign_l;
  logic        own_l;
  logic [7:0]  sh;
  logic [11:0] bcd;

  logic        dwell_done;
  logic        grant_op;
  logic        pick1;
  logic        last_conv;
  logic [7:0]  val_w;
  logic [7:0]  mag;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_nx;
  logic [7:0]  sh_nx;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign dwell_done = (dwell_cnt >= DWELL_M1);
  assign grant_op   = ((state == IDLE) ||
                       ((state == SHOW) && dwell_done)) &&
                      (req0 || req1);
  // Tie goes to whoever was not granted last.
  assign pick1      = req1 && (!req0 || !last);
  assign last_conv  = (bit_cnt == 3'd7);
  assign val_w      = pick1 ? val1 : val0;
  // -128 negates to 8'h80, which reads as 128 unsigned.
  assign mag        = val_w[7] ? (~val_w + 8'd1) : val_w;

  assign bcd_adj = {add3(bcd[11:8]),
                    add3(bcd[7:4]),
                    add3(bcd[3:0])};
  assign {bcd_nx, sh_nx} = {bcd_adj[10:0], sh, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (grant_op)  state_nx = CONV;
      CONV: if (last_conv) state_nx = SHOW;
      SHOW: if (grant_op)  state_nx = CONV;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      last      <= 1'b1;
      sign_l    <= 1'b0;
      own_l     <= 1'b0;
      sh        <= 8'd0;
      bcd       <= 12'd0;
      bit_cnt   <= 3'd0;
      dwell_cnt <= 26'd0;
      valid     <= 1'b0;
      owner     <= 1'b0;
      sign      <= 1'b0;
      hunds     <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
    end else begin
      gnt0 <= grant_op && !pick1;
      gnt1 <= grant_op && pick1;
      if (grant_op) begin
        last    <= pick1;
        own_l   <= pick1;
        sign_l  <= val_w[7];
        sh      <= mag;
        bcd     <= 12'd0;
        bit_cnt <= 3'd0;
      end else if (state == CONV) begin
        sh      <= sh_nx;
        bcd     <= bcd_nx;
        bit_cnt <= bit_cnt + 3'd1;
        if (last_conv) begin
          hunds     <= bcd_nx[11:8];
          tens      <= bcd_nx[7:4];
          ones      <= bcd_nx[3:0];
          sign      <= sign_l;
          owner     <= own_l;
          valid     <= 1'b1;
          dwell_cnt <= 26'd0;
        end
      end else if (state == SHOW) begin
        if (!dwell_done) dwell_cnt <= dwell_cnt + 26'd1;
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: random and corner conversions against a
// decimal reference, arbitration, dwell timing and reset abort.
module tb_display_scheduler;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic req0 = 0, req1 = 0;
  logic [7:0] val0 = 0, val1 = 0;
  logic gnt0, gnt1, busy, valid, owner, sign;
  logic [3:0] hunds, tens, ones;

  logic req0_b = 0, req1_b = 0;
  logic [7:0] val0_b = 0, val1_b = 0;
  logic gnt0_b, gnt1_b, busy_b, valid_b, owner_b, sign_b;
  logic [3:0] hunds_b, tens_b, ones_b;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_disp = '0;
  logic [14:0] disp;

  assign disp = {valid, owner, sign, hunds, tens, ones};

  always #5 clk = ~clk;

  display_scheduler #(.DWELL(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .val0(val0),
    .req1(req1), .val1(val1),
    .gnt0(gnt0), .gnt1(gnt1),
    .busy(busy), .valid(valid),
    .owner(owner), .sign(sign),
    .hunds(hunds), .tens(tens), .ones(ones)
  );

  display_scheduler #(.DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .val0(val0_b),
    .req1(req1_b), .val1(val1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b),
    .busy(busy_b), .valid(valid_b),
    .owner(owner_b), .sign(sign_b),
    .hunds(hunds_b), .tens(tens_b), .ones(ones_b)
  );

  // Decimal reference: magnitude by arithmetic, digits by div/mod.
  function automatic logic [14:0] disp_of(
    input logic own, input logic [7:0] v);
    int m;
    m = v[7] ? 256 - int'(v) : int'(v);
    return {1'b1, own, v[7],
            4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt0, gnt1, busy, disp} !== 18'd0) begin
      errors++;
      $display("FAIL reset: got %h want 0",
               {gnt0, gnt1, busy, disp});
    end
    rst_n = 1'b1;
    exp_disp = '0;
  endtask

  task automatic test_convert(input logic r, input logic [7:0] v);
    int n;
    logic [14:0] want;
    if (r) begin req1 = 1; val1 = v; end
    else   begin req0 = 1; val0 = v; end
    n = 0;
    do begin
      tick();
      n++;
    end while (!(gnt0 || gnt1) && n < 20);
    checks++;
    if ({gnt1, gnt0} !== (r ? 2'b10 : 2'b01) || busy !== 1'b1) begin
      errors++;
      $display("FAIL grant r=%0d: got g1g0=%b busy=%b",
               r, {gnt1, gnt0}, busy);
    end
    req0 = 0;
    req1 = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if ({busy, gnt0, gnt1, disp} !== {3'b100, exp_disp}) begin
        errors++;
        $display("FAIL conv_hold k=%0d: got %h want %h", k,
                 {busy, gnt0, gnt1, disp}, {3'b100, exp_disp});
      end
    end
    tick();
    want = disp_of(r, v);
    checks++;
    if ({busy, disp} !== {1'b0, want}) begin
      errors++;
      $display("FAIL result v=%h: got %h want %h",
               v, {busy, disp}, {1'b0, want});
    end
    exp_disp = want;
  endtask

  task automatic test_ignore();
    int n;
    logic [7:0] v;
    v = 8'($urandom);
    req0 = 1;
    val0 = v;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gnt0 && n < 20);
    req0 = 0;
    for (int k = 1; k <= 8; k++) begin
      req1 = 1'($urandom);
      val1 = 8'($urandom);
      tick();
      checks++;
      if (gnt1 !== 1'b0 || (k < 8 && disp !== exp_disp)) begin
        errors++;
        $display("FAIL ign_conv k=%0d: gnt1=%b disp=%h want %h",
                 k, gnt1, disp, exp_disp);
      end
    end
    exp_disp = disp_of(1'b0, v);
    checks++;
    if (disp !== exp_disp) begin
      errors++;
      $display("FAIL ign_result: got %h want %h", disp, exp_disp);
    end
    // Pulse req1 on SHOW edges 1 and 3 (dwell not yet done).
    for (int k = 1; k <= 5; k++) begin
      req1 = (k == 1 || k == 3);
      tick();
      checks++;
      if ({gnt0, gnt1, busy} !== 3'b000 || disp !== exp_disp) begin
        errors++;
        $display("FAIL ign_show k=%0d: g0g1b=%b disp=%h",
                 k, {gnt0, gnt1, busy}, disp);
      end
    end
    val1 = 8'h9C;
    req1 = 1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL ign_late_grant: got g0g1=%b want 01",
               {gnt0, gnt1});
    end
    req1 = 0;
    repeat (8) tick();
    exp_disp = disp_of(1'b1, 8'h9C);
    checks++;
    if (disp !== exp_disp) begin
      errors++;
      $display("FAIL ign_r1: got %h want %h", disp, exp_disp);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (DW) tick();
    req0 = 1;
    val0 = 8'h85;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gnt0 && n < 20);
    req0 = 0;
    repeat (4) tick();
    rst_n = 0;
    tick();
    checks++;
    if ({gnt0, gnt1, busy, disp} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h want 0",
               {gnt0, gnt1, busy, disp});
    end
    rst_n = 1;
    exp_disp = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if ({busy, disp} !== 16'd0) begin
        errors++;
        $display("FAIL rst_abort k=%0d: got %h want 0",
                 k, {busy, disp});
      end
    end
  endtask

  task automatic test_back_to_back();
    int last_done;
    int ngr;
    logic who_exp;
    logic pend;
    logic prev_busy;
    logic [7:0] vv [2];
    vv[0] = 8'd5;
    vv[1] = 8'hFF;
    rst_n = 0;
    req0 = 1; val0 = vv[0];
    req1 = 1; val1 = vv[1];
    tick();
    rst_n = 1;
    last_done = -1;
    ngr = 0;
    who_exp = 1'b0;
    pend = 1'b0;
    prev_busy = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (cyc == 0) begin
        checks++;
        if (gnt0 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_first: gnt0=%b want 1", gnt0);
        end
      end
      if (gnt0 || gnt1) begin
        checks++;
        if ((gnt0 && gnt1) || gnt1 !== who_exp ||
            (last_done >= 0 && cyc - last_done != DW)) begin
          errors++;
          $display("FAIL b2b_grant cyc=%0d: g1g0=%b want r%0d gap=%0d want %0d",
                   cyc, {gnt1, gnt0}, who_exp, cyc - last_done, DW);
        end
        pend = gnt1;
        who_exp = ~gnt1;
        ngr++;
      end
      if (prev_busy && !busy) begin
        checks++;
        if (disp !== disp_of(pend, vv[pend])) begin
          errors++;
          $display("FAIL b2b_result r%0d: got %h want %h",
                   pend, disp, disp_of(pend, vv[pend]));
        end
        last_done = cyc;
      end
      prev_busy = busy;
    end
    checks++;
    if (ngr < 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d grants want >=4", ngr);
    end
    req0 = 0;
    req1 = 0;
    repeat (10) tick();
  endtask

  // DWELL=1 instance: each round is the grant edge, 8 conversion
  // edges, then one SHOW edge that is already dwell-done.
  task automatic test_dwell1();
    int last_g;
    int ngr;
    rst_n = 0;
    req1_b = 1;
    val1_b = 8'($urandom);
    tick();
    rst_n = 1;
    last_g = -1;
    ngr = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      tick();
      if (gnt0_b) begin
        checks++;
        errors++;
        $display("FAIL d1_gnt0 cyc=%0d: got 1 want 0", cyc);
      end
      if (gnt1_b) begin
        if (last_g >= 0) begin
          checks++;
          if (cyc - last_g != 9) begin
            errors++;
            $display("FAIL d1_period: got %0d want 9", cyc - last_g);
          end
        end
        last_g = cyc;
        ngr++;
      end
    end
    checks++;
    if (ngr < 5) begin
      errors++;
      $display("FAIL d1_count: got %0d want >=5", ngr);
    end
    req1_b = 0;
  endtask

  initial begin
    logic [7:0] cv [7];
    logic       cr [7];
    cv = '{8'h85, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h9C};
    cr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    test_reset();
    for (int i = 0; i < 7; i++) test_convert(cr[i], cv[i]);
    for (int i = 0; i < 10; i++)
      test_convert(1'($urandom), 8'($urandom));
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
